// File: rtl/trivium_stream_core_pkg.sv
// trivium_pkg: shared constants, tap positions, FSM encoding and the
// key/IV load helper for the Trivium stream core.
// Tap and boundary constants use the 1-based s1..s288 numbering; state
// vectors store s_i at bit [i-1].
package trivium_pkg;

  localparam int unsigned STATE_LEN = 288;
  localparam int unsigned KEY_W     = 80;
  localparam int unsigned IV_W      = 80;

  // Last cell of register A (s1..s93) and register B (s94..s177).
  localparam int unsigned A_END = 93;
  localparam int unsigned B_END = 177;

  // t1 feeds register B, t2 feeds register C, t3 feeds register A.
  localparam int unsigned TAP_T1_A   = 66;
  localparam int unsigned TAP_T1_B   = 93;
  localparam int unsigned TAP_T1_ANDA = 91;
  localparam int unsigned TAP_T1_ANDB = 92;
  localparam int unsigned TAP_T1_C   = 171;
  localparam int unsigned TAP_T2_A   = 162;
  localparam int unsigned TAP_T2_B   = 177;
  localparam int unsigned TAP_T2_ANDA = 175;
  localparam int unsigned TAP_T2_ANDB = 176;
  localparam int unsigned TAP_T2_C   = 264;
  localparam int unsigned TAP_T3_A   = 243;
  localparam int unsigned TAP_T3_B   = 288;
  localparam int unsigned TAP_T3_ANDA = 286;
  localparam int unsigned TAP_T3_ANDB = 287;
  localparam int unsigned TAP_T3_C   = 69;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } fsm_state_e;

  // Initial state: key into s1..s80 (key[0] -> s1), iv into s94..s173,
  // s286..s288 set, everything else clear.
  function automatic logic [STATE_LEN-1:0] load_state(
    input logic [KEY_W-1:0] key,
    input logic [IV_W-1:0]  iv
  );
    logic [STATE_LEN-1:0] st;
    st = '0;
    st[KEY_W-1:0] = key;
    st[A_END+IV_W-1:A_END] = iv;
    st[STATE_LEN-1:STATE_LEN-3] = '1;
    return st;
  endfunction

endpackage

// File: rtl/trivium_stream_core_if.sv
// trivium_stream_core_if: valid/ready word stream.
//   valid - word present (driven by master)
//   ready - word taken when valid & ready (driven by slave)
//   data  - DATA_W-bit payload (driven by master)
interface trivium_stream_core_if #(
  parameter int unsigned DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/trivium_stream_core_step.sv
// trivium_step: BPC Trivium rounds chained combinationally.
//   state_in  - 288-bit state before the rounds
//   state_out - state after BPC rounds
//   z         - keystream bits, z[0] from the first round
module trivium_step
  import trivium_pkg::*;
#(
  parameter int unsigned BPC = 1
) (
  input  logic [STATE_LEN-1:0] state_in,
  output logic [STATE_LEN-1:0] state_out,
  output logic [BPC-1:0]       z
);

  always_comb begin
    logic [STATE_LEN-1:0] st;
    logic t1, t2, t3;
    st = state_in;
    z  = '0;
    t1 = 1'b0;
    t2 = 1'b0;
    t3 = 1'b0;
    for (int unsigned r = 0; r < BPC; r++) begin
      t1 = st[TAP_T1_A-1] ^ st[TAP_T1_B-1];
      t2 = st[TAP_T2_A-1] ^ st[TAP_T2_B-1];
      t3 = st[TAP_T3_A-1] ^ st[TAP_T3_B-1];
      z[r] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (st[TAP_T1_ANDA-1] & st[TAP_T1_ANDB-1]) ^ st[TAP_T1_C-1];
      t2 = t2 ^ (st[TAP_T2_ANDA-1] & st[TAP_T2_ANDB-1]) ^ st[TAP_T2_C-1];
      t3 = t3 ^ (st[TAP_T3_ANDA-1] & st[TAP_T3_ANDB-1]) ^ st[TAP_T3_C-1];
      // Each register shifts towards its high end; feedback enters its first cell.
      st = {st[STATE_LEN-2:B_END], t2,
            st[B_END-2:A_END],     t1,
            st[A_END-2:0],         t3};
    end
    state_out = st;
  end

endmodule

// File: rtl/trivium_stream_core.sv
// trivium_stream_core: Trivium keystream XOR engine on a valid/ready stream.
//   clk, rst_n   - clock, asynchronous active-low reset
//   init         - one-cycle pulse: load key/iv and restart warm-up
//   key, iv      - 80-bit key and IV, sampled only on init
//   busy         - high while warming up
//   keyed        - high in RUN (keystream available)
//   s_stream     - input words (slave): plaintext or ciphertext
//   m_stream     - output words (master): input XOR keystream
// A DATA_W keystream buffer is filled BPC bits per clock (first bit at LSB)
// and the state is frozen while the buffer is full.
module trivium_stream_core
  import trivium_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BPC           = 1,
  parameter int unsigned WARMUP_ROUNDS = 1152
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  output logic             busy,
  output logic             keyed,
  trivium_stream_core_if.slave  s_stream,
  trivium_stream_core_if.master m_stream
);

  localparam int unsigned WARMUP_CYCLES = WARMUP_ROUNDS / BPC;
  localparam int unsigned SLICES        = DATA_W / BPC;
  localparam int unsigned RND_W         = $clog2(WARMUP_CYCLES + 1);
  localparam int unsigned SLC_W         = $clog2(SLICES + 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(WARMUP_CYCLES - 1);
  localparam logic [SLC_W-1:0] SLC_LAST = SLC_W'(SLICES - 1);

  fsm_state_e           fsm_q, fsm_d;
  logic [STATE_LEN-1:0] st_q, st_d, st_step;
  logic [BPC-1:0]       z;
  logic [RND_W-1:0]     rnd_q, rnd_d;
  logic [SLC_W-1:0]     slc_q, slc_d;
  logic [DATA_W-1:0]    ks_q, ks_d;
  logic                 ks_full_q, ks_full_d;
  logic                 m_valid_q, m_valid_d;
  logic [DATA_W-1:0]    m_data_q, m_data_d;
  logic                 s_ready;
  logic                 accept;

  trivium_step #(.BPC(BPC)) u_step (
    .state_in  (st_q),
    .state_out (st_step),
    .z         (z)
  );

  assign busy  = (fsm_q == WARMUP);
  assign keyed = (fsm_q == RUN);
  // init also masks ready so the upstream never sees a handshake that init discards.
  assign s_ready = keyed & ks_full_q & (~m_valid_q | m_stream.ready) & ~init;
  assign accept  = s_stream.valid & s_ready;

  assign s_stream.ready = s_ready;
  assign m_stream.valid = m_valid_q;
  assign m_stream.data  = m_data_q;

  always_comb begin
    fsm_d     = fsm_q;
    st_d      = st_q;
    rnd_d     = rnd_q;
    slc_d     = slc_q;
    ks_d      = ks_q;
    ks_full_d = ks_full_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    if (init) begin
      st_d      = load_state(key, iv);
      fsm_d     = WARMUP;
      rnd_d     = '0;
      slc_d     = '0;
      ks_full_d = 1'b0;
      m_valid_d = 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: ;
        WARMUP: begin
          st_d = st_step;
          // Counter stops at its last value rather than wrapping.
          if (rnd_q == RND_LAST) fsm_d = RUN;
          else                   rnd_d = rnd_q + 1'b1;
        end
        RUN: begin
          if (!ks_full_q) begin
            st_d = st_step;
            ks_d[slc_q*BPC +: BPC] = z;
            if (slc_q == SLC_LAST) begin
              slc_d     = '0;
              ks_full_d = 1'b1;
            end else begin
              slc_d = slc_q + 1'b1;
            end
          end
        end
        default: fsm_d = IDLE;
      endcase

      if (m_valid_q && m_stream.ready) m_valid_d = 1'b0;
      // accept implies ks_full_q, so it never collides with buffer filling.
      if (accept) begin
        m_data_d  = s_stream.data ^ ks_q;
        m_valid_d = 1'b1;
        ks_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      st_q      <= '0;
      rnd_q     <= '0;
      slc_q     <= '0;
      ks_q      <= '0;
      ks_full_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      fsm_q     <= fsm_d;
      st_q      <= st_d;
      rnd_q     <= rnd_d;
      slc_q     <= slc_d;
      ks_q      <= ks_d;
      ks_full_q <= ks_full_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

endmodule

// File: doc/trivium_stream_core.md
Name: trivium_stream_core

Overview:
Parametrised Trivium keystream cipher core, the next generation of the trivium_lite block. It loads a full 80-bit key and 80-bit IV and runs the standard warm-up. It then XORs keystream onto a valid/ready plaintext stream. The datapath width and the number of bits produced per clock are configurable. It sits between a host byte interface and any downstream consumer. Encryption and decryption are the same operation.

Parameters:
DATA_W, 8, width of the plaintext/ciphertext words; must be a multiple of BPC.
BPC, 1, keystream bits produced per clock (unrolled rounds); allowed values are 1, 2, 4, 8, 16, 32, 64.
WARMUP_ROUNDS, 1152, initialisation rounds before keystream is used; must be a multiple of BPC.

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
init  in  1  single-cycle pulse; samples key/iv and starts (re)initialisation
key  in  80  cipher key, sampled only on init
iv  in  80  initialisation vector, sampled only on init
busy  out  1  high during warm-up
keyed  out  1  high once warm-up is complete (RUN state)
s_valid  in  1  input word valid
s_ready  out  1  input word accepted this cycle when s_valid & s_ready
s_data  in  DATA_W  plaintext or ciphertext in
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_data  out  DATA_W  s_data XOR keystream

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; 288-bit state register all zeros; counters zero; ks_full=0.
  - busy=0, keyed=0, s_ready=0, m_valid=0, m_data=0.
- Load on init (any state): state s1..s80=key[79:0] (key[0]→s1), s81..s93=0; s94..s173=iv, s174..s177=0; s178..s285=0, s286..s288=1.
  - m_valid cleared, ks_full cleared, round counter zeroed, next state WARMUP.
- One round:
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
  - t1^=s91&s92^s171, t2^=s175&s176^s264, t3^=s286&s287^s69.
  - Shift: s1..93←(t3,s1..92), s94..177←(t1,s94..176), s178..288←(t2,s178..287).
  - BPC rounds are chained combinationally per clock.
- FSM:
  - IDLE→WARMUP on init.
  - WARMUP: advance BPC rounds per cycle, discard z; after WARMUP_ROUNDS/BPC cycles →RUN.
  - busy=1 exactly those cycles; keyed=1 in RUN.
  - No transition out of RUN except init or reset.
- Keystream buffer (RUN only):
  - While ks_full=0, advance BPC rounds per cycle, packing z into ks[DATA_W-1:0].
  - The first generated bit goes to the LSB; slice k occupies bits [k*BPC +: BPC].
  - On the cycle the last slice is written, set ks_full=1 and stop the state.
- Handshake:
  - s_ready = keyed & ks_full & (!m_valid | m_ready).
  - On accept: m_data<=s_data^ks, m_valid<=1, ks_full<=0; generation resumes the next cycle.
  - m_valid holds and m_data stays stable until m_valid&m_ready.
  - Simultaneous drain and accept is allowed (no bubble).
- Latency and throughput:
  - Accepted word to m_valid: 1 cycle.
  - Minimum word period: DATA_W/BPC+1 cycles.
- Boundaries:
  - init with s_valid high: init wins, no word is accepted that cycle.
  - init during RUN with m_valid pending: the word is dropped.
  - s_valid while not keyed: ignored (s_ready=0).
  - Round counter saturates; there is no wrap.

Decomposition:
- Shared package trivium_pkg:
  - STATE_LEN=288, KEY_W=80, IV_W=80.
  - Tap index constants (66, 93, 91, 92, 171, 162, 177, 175, 176, 264, 243, 288, 286, 287, 69).
  - Register boundaries 93/177.
  - FSM state enum {IDLE, WARMUP, RUN}.
- Sub-module trivium_step: purely combinational, parameter BPC; state_in → state_out plus z[BPC-1:0].
- Top: FSM, counters, ks buffer, handshake.

Test Plan:
- Reset plus init with BPC=1 → busy high exactly 1152 cycles; keyed rises the next cycle; s_ready=0 throughout; all outputs 0 during reset.
- key=0, iv=0, s_data=0x00 ×4 → m_data equals golden C model keystream bytes (LSB-first packing), bit-exact.
- key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA98765432100011: encrypt DE AD BE EF; re-init with the same key/iv; feed the ciphertext → DE AD BE EF returned in order.
- m_ready held low 20 cycles after the first output → m_data stable, s_ready=0, no loss or duplication; after release, 4 words delivered in order.
- init pulsed while m_valid=1 mid-stream → m_valid low the next cycle, busy=1; subsequent keystream identical to a fresh start with the same key/iv.
- BPC=8 build → keystream byte-identical to BPC=1; warm-up takes 144 cycles; steady word period is 2 cycles with s_valid and m_ready held high.
